// File: rtl/router_add_seq_pkg.sv
// ============================================================================
// Module      : router_add_seq_pkg
// Description : Shared types and field widths for the adder-router sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_add_seq_pkg;

    localparam int OP_W    = 3;
    localparam int ISEL_W  = 2;
    localparam int OSEL_W  = 3;
    localparam int RPT_W   = 4;
    localparam int ENTRY_W = OP_W + ISEL_W + OSEL_W + RPT_W;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'b000,
        OP_PS   = 3'b001,
        OP_BYP  = 3'b010,
        OP_ADD  = 3'b011,
        OP_CONS = 3'b100,
        OP_SUM  = 3'b101
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ISEL_W-1:0] input_sel;
        logic [OSEL_W-1:0] output_sel;
        logic [RPT_W-1:0]  rpt;
    } entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic add_en;
        logic consec_add_en;
        logic bypass_en;
        logic ps_en;
        logic sum_en;
    } en_t;

    // Op codes 110 and 111 fall through to the NOP result.
    function automatic en_t decode_op(input op_e op);
        en_t en;
        en = '0;
        case (op)
            OP_PS:   en.ps_en         = 1'b1;
            OP_BYP:  en.bypass_en     = 1'b1;
            OP_ADD:  en.add_en        = 1'b1;
            OP_CONS: en.consec_add_en = 1'b1;
            OP_SUM:  en.sum_en        = 1'b1;
            default: en = '0;
        endcase
        return en;
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_add_seq_cmem.sv
// ============================================================================
// Module      : router_add_seq_cmem
// Description : DEPTH x ENTRY_W control register file, one write port,
//               combinational read port, no reset on contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_add_seq_cmem
    import router_add_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/router_add_seq.sv
// ============================================================================
// Module      : router_add_seq
// Description : Control-memory sequencer driving the adder-router datapath.
//               Optional macro ROUTER_ADD_SEQ_LOOP_EN adds loop_en for
//               continuous program replay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_add_seq
    import router_add_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic [AW-1:0]      last_addr,
`ifdef ROUTER_ADD_SEQ_LOOP_EN
    input  logic               loop_en,
`endif
    output logic               busy,
    output logic               done,
    output logic               add_sel,
    output logic               add_en,
    output logic               consec_add_en,
    output logic               bypass_en,
    output logic               ps_en,
    output logic               sum_en,
    output logic [ISEL_W-1:0]  input_sel,
    output logic [OSEL_W-1:0]  output_sel
);

    localparam logic [AW-1:0] c_PC_MAX = AW'(DEPTH - 1);

    state_e             r_state,  w_state_nxt;
    logic [AW-1:0]      r_pc,     w_pc_nxt;
    logic [AW-1:0]      r_last,   w_last_nxt;
    logic [RPT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic               r_fin,    w_fin_nxt;
    logic               r_wrap,   w_wrap_nxt;
    en_t                r_en,     w_en_nxt;
    logic [ISEL_W-1:0]  r_isel,   w_isel_nxt;
    logic [OSEL_W-1:0]  r_osel,   w_osel_nxt;
    logic               r_add_sel, w_add_sel_nxt;
    logic               r_done,   w_done_nxt;

    logic [ENTRY_W-1:0] w_rd_data;
    entry_t             w_entry;
    logic               w_loop;

`ifdef ROUTER_ADD_SEQ_LOOP_EN
    assign w_loop = loop_en;
`else
    assign w_loop = 1'b0;
`endif

    router_add_seq_cmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_cmem (
        .clk     (clk),
        .wr_en   (wr_en && (r_state == ST_IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r_pc),
        .rd_data (w_rd_data)
    );

    assign w_entry = entry_t'(w_rd_data);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_fin marks the cycle holding the final entry's last repeat; the edge
    // after it clears the outputs and raises done.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_fin_nxt     = r_fin;
        w_wrap_nxt    = 1'b0;
        w_en_nxt      = '0;
        w_isel_nxt    = '0;
        w_osel_nxt    = '0;
        w_add_sel_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = last_addr;
                    w_fin_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop || r_fin) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_fin_nxt   = 1'b0;
                    w_done_nxt  = !stop;
                end else begin
                    w_en_nxt      = decode_op(w_entry.op);
                    w_isel_nxt    = w_entry.input_sel;
                    w_osel_nxt    = w_entry.output_sel;
                    w_add_sel_nxt = (|w_en_nxt) || (|r_en);
                    w_done_nxt    = r_wrap;
                    if (r_cnt == w_entry.rpt) begin
                        w_cnt_nxt = '0;
                        if (r_pc == r_last) begin
                            if (w_loop) begin
                                w_pc_nxt   = '0;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_fin_nxt  = 1'b1;
                            end
                        end else if (r_pc != c_PC_MAX) begin
                            w_pc_nxt = r_pc + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_pc      <= '0;
            r_last    <= '0;
            r_cnt     <= '0;
            r_fin     <= 1'b0;
            r_wrap    <= 1'b0;
            r_en      <= '0;
            r_isel    <= '0;
            r_osel    <= '0;
            r_add_sel <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fin     <= w_fin_nxt;
            r_wrap    <= w_wrap_nxt;
            r_en      <= w_en_nxt;
            r_isel    <= w_isel_nxt;
            r_osel    <= w_osel_nxt;
            r_add_sel <= w_add_sel_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign busy          = (r_state == ST_RUN);
    assign done          = r_done;
    assign add_sel       = r_add_sel;
    assign add_en        = r_en.add_en;
    assign consec_add_en = r_en.consec_add_en;
    assign bypass_en     = r_en.bypass_en;
    assign ps_en         = r_en.ps_en;
    assign sum_en        = r_en.sum_en;
    assign input_sel     = r_isel;
    assign output_sel    = r_osel;

endmodule

`default_nettype wire

// File: tb/tb_router_add_seq.sv
// ============================================================================
// Module      : tb_router_add_seq
// Description : Directed vector bench for router_add_seq (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_add_seq;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  last_addr = '0;
`ifdef ROUTER_ADD_SEQ_LOOP_EN
    logic        loop_en = 1'b0;
`endif
    logic        busy, done, add_sel, add_en, consec_add_en, bypass_en, ps_en, sum_en;
    logic [1:0]  input_sel;
    logic [2:0]  output_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    router_add_seq #(.DEPTH(16)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .stop          (stop),
        .last_addr     (last_addr),
`ifdef ROUTER_ADD_SEQ_LOOP_EN
        .loop_en       (loop_en),
`endif
        .busy          (busy),
        .done          (done),
        .add_sel       (add_sel),
        .add_en        (add_en),
        .consec_add_en (consec_add_en),
        .bypass_en     (bypass_en),
        .ps_en         (ps_en),
        .sum_en        (sum_en),
        .input_sel     (input_sel),
        .output_sel    (output_sel)
    );

    // Enable patterns ordered {add, cons, byp, ps, sum}
    localparam logic [4:0] E0 = 5'b00000, EADD = 5'b10000, ECON = 5'b01000,
                           EBYP = 5'b00100, EPS = 5'b00010, ESUM = 5'b00001;

    localparam logic [11:0] W_PS    = 12'b001_00_010_0000;
    localparam logic [11:0] W_ADD   = 12'b011_01_000_0010;
    localparam logic [11:0] W_SUM   = 12'b101_00_100_0000;
    localparam logic [11:0] W_RSV   = 12'b111_11_101_0011;
    localparam logic [11:0] W_BYP   = 12'b010_10_011_0000;
    localparam logic [11:0] W_NOP   = 12'b000_00_111_0000;
    localparam logic [11:0] W_CONS  = 12'b100_11_001_0001;
    localparam logic [11:0] W_SUM1  = 12'b101_00_100_0001;

    typedef struct {
        logic        st;
        logic        sp;
        logic        we;
        logic [3:0]  wa;
        logic [11:0] wd;
        logic [3:0]  la;
        logic [12:0] exp;   // {busy, done, en[4:0], isel, osel, add_sel}
    } vec_t;

    vec_t tbl [64];
    int   n = 0;

    task automatic push(input logic st, input logic sp, input logic we, input logic [3:0] wa,
                        input logic [11:0] wd, input logic [3:0] la, input logic b, input logic d,
                        input logic [4:0] en, input logic [1:0] is, input logic [2:0] os,
                        input logic asel);
        tbl[n].st  = st;
        tbl[n].sp  = sp;
        tbl[n].we  = we;
        tbl[n].wa  = wa;
        tbl[n].wd  = wd;
        tbl[n].la  = la;
        tbl[n].exp = {b, d, en, is, os, asel};
        n++;
    endtask

    function automatic logic [12:0] actual();
        return {busy, done, add_en, consec_add_en, bypass_en, ps_en, sum_en,
                input_sel, output_sel, add_sel};
    endfunction

    task automatic chk(input string name, input int idx, input logic [12:0] exp);
        logic [12:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got={busy,done,en,isel,osel,add_sel}=%b required=%b",
                     name, idx, act, exp);
        end
    endtask

    task automatic apply_rows(input string name, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            start     = tbl[i].st;
            stop      = tbl[i].sp;
            wr_en     = tbl[i].we;
            wr_addr   = tbl[i].wa;
            wr_data   = tbl[i].wd;
            last_addr = tbl[i].la;
            @(negedge clk);
            chk(name, i, tbl[i].exp);
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic idle_cycle(input string name, input int idx, input logic [12:0] exp);
        @(negedge clk);
        chk(name, idx, exp);
    endtask

    int f_first;

    initial begin
        // Load basic program
        push(0,0,1,4'd0,W_PS ,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        push(0,0,1,4'd1,W_ADD,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        push(0,0,1,4'd2,W_SUM,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        // Basic run
        push(1,0,0,4'd0,12'h0,4'd2, 1,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EPS ,2'b00,3'b010,1);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,ESUM,2'b00,3'b100,1);
        push(0,0,0,4'd0,12'h0,4'd2, 0,1,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        // Abort on the second ADD cycle
        push(1,0,0,4'd0,12'h0,4'd2, 1,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EPS ,2'b00,3'b010,1);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,1,0,4'd0,12'h0,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        // start and write to entry 0 while busy are ignored
        push(1,0,0,4'd0,12'h0 ,4'd2, 1,0,E0  ,2'b00,3'b000,0);
        push(1,0,1,4'd0,W_RSV ,4'd2, 1,0,EPS ,2'b00,3'b010,1);
        push(1,0,0,4'd0,12'h0 ,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,EADD,2'b01,3'b000,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,ESUM,2'b00,3'b100,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 0,1,E0  ,2'b00,3'b000,0);
        // Entry 0 readback as a one-entry program
        push(1,0,0,4'd0,12'h0 ,4'd0, 1,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 1,0,EPS ,2'b00,3'b010,1);
        push(0,0,0,4'd0,12'h0 ,4'd0, 0,1,E0  ,2'b00,3'b000,0);
        // Reserved op with start and write in the same cycle
        push(1,0,1,4'd0,W_RSV ,4'd0, 1,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 1,0,E0  ,2'b11,3'b101,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 1,0,E0  ,2'b11,3'b101,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 1,0,E0  ,2'b11,3'b101,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 1,0,E0  ,2'b11,3'b101,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 0,1,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0 ,4'd0, 0,0,E0  ,2'b00,3'b000,0);
        // BYP / NOP / CONS program, add_sel trailing cycle over the NOP
        push(0,0,1,4'd0,W_BYP ,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        push(0,0,1,4'd1,W_NOP ,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        push(0,0,1,4'd2,W_CONS,4'd2, 0,0,E0  ,2'b00,3'b000,0);
        f_first = n;
        push(1,0,0,4'd0,12'h0 ,4'd2, 1,0,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,EBYP,2'b10,3'b011,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,E0  ,2'b00,3'b111,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,ECON,2'b11,3'b001,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 1,0,ECON,2'b11,3'b001,1);
        push(0,0,0,4'd0,12'h0 ,4'd2, 0,1,E0  ,2'b00,3'b000,0);
        push(0,0,0,4'd0,12'h0 ,4'd2, 0,0,E0  ,2'b00,3'b000,0);

        // Reset state
        rstb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset", 0, 13'd0);
        rstb = 1'b1;

        apply_rows("vec", 0, n - 1);

        // Reset in the middle of a run, then replay
        start = 1'b1; last_addr = 4'd2;
        @(negedge clk);
        start = 1'b0;
        idle_cycle("rst_run", 0, {1'b1, 1'b0, EBYP, 2'b10, 3'b011, 1'b1});
        rstb = 1'b0;
        idle_cycle("rst_run", 1, 13'd0);
        rstb = 1'b1;
        idle_cycle("rst_run", 2, 13'd0);
        apply_rows("replay", f_first, n - 1);

`ifdef ROUTER_ADD_SEQ_LOOP_EN
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = W_PS;
        @(negedge clk);
        wr_addr = 4'd1; wr_data = W_SUM1;
        @(negedge clk);
        wr_en = 1'b0;
        loop_en = 1'b1; last_addr = 4'd1; start = 1'b1;
        idle_cycle("loop", 0, {1'b1, 1'b0, E0,   2'b00, 3'b000, 1'b0});
        start = 1'b0;
        idle_cycle("loop", 1, {1'b1, 1'b0, EPS,  2'b00, 3'b010, 1'b1});
        idle_cycle("loop", 2, {1'b1, 1'b0, ESUM, 2'b00, 3'b100, 1'b1});
        idle_cycle("loop", 3, {1'b1, 1'b0, ESUM, 2'b00, 3'b100, 1'b1});
        idle_cycle("loop", 4, {1'b1, 1'b1, EPS,  2'b00, 3'b010, 1'b1});
        idle_cycle("loop", 5, {1'b1, 1'b0, ESUM, 2'b00, 3'b100, 1'b1});
        idle_cycle("loop", 6, {1'b1, 1'b0, ESUM, 2'b00, 3'b100, 1'b1});
        idle_cycle("loop", 7, {1'b1, 1'b1, EPS,  2'b00, 3'b010, 1'b1});
        stop = 1'b1;
        idle_cycle("loop", 8, 13'd0);
        stop = 1'b0; loop_en = 1'b0;
        idle_cycle("loop", 9, 13'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/router_add_seq.md
ROUTER_ADD_SEQ -- requirements
Module: router_add_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of control-memory entries; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning the control-memory address width.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rstb, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have ports wr_en (input, 1), wr_addr (input, AW) and wr_data (input, 12): host write port for the control memory.
REQ-006 SHALL have ports start (input, 1), stop (input, 1) and last_addr (input, AW): program launch, abort, and index of the final entry.
REQ-007 SHALL have ports busy (output, 1) and done (output, 1): sequencer status.
REQ-008 SHALL have control outputs, all registered, driven to the adder-router datapath:
- add_sel (1)
- add_en (1)
- consec_add_en (1)
- bypass_en (1)
- ps_en (1)
- sum_en (1)
- input_sel (2)
- output_sel (3)

Function
REQ-009 SHALL format each entry as wr_data[11:9]=op, [8:7]=input_sel, [6:4]=output_sel, [3:0]=rpt.
REQ-010 SHALL decode op as follows; any other op code SHALL act as NOP:
- 000 = NOP: no enable asserted
- 001 = PS: ps_en
- 010 = BYP: bypass_en
- 011 = ADD: add_en
- 100 = CONS: consec_add_en
- 101 = SUM: sum_en
REQ-011 SHALL implement a two-state FSM, IDLE and RUN, with busy=1 exactly while in RUN.
REQ-012 SHALL accept start only in IDLE; in the same edge it SHALL capture last_addr, set pc=0, clear the repeat counter and enter RUN.
REQ-013 SHALL ignore start while in RUN.
REQ-014 SHALL drive the entry-0 decode on the outputs in the cycle after the first RUN edge, i.e. 2 cycles after start is sampled.
REQ-015 SHALL hold the outputs of entry k for exactly rpt_k+1 consecutive cycles, and SHALL present consecutive entries back-to-back with no gap cycle.
REQ-016 SHALL drive input_sel and output_sel from the entry for every op; for NOP they SHALL still be driven but carry no meaning.
REQ-017 SHALL assert add_sel in every cycle in which any enable output is high, plus the single following cycle so the downstream register update is clocked.
REQ-018 SHALL, after the last cycle of entry last_addr, zero all control outputs on the next edge, return to IDLE and pulse done high for exactly 1 cycle.
REQ-019 SHALL handle last_addr=0 as a one-entry program.
REQ-020 SHALL saturate pc at DEPTH-1; it SHALL never wrap mid-program.
REQ-021 SHALL, when stop is sampled in RUN, take priority over everything else: outputs zero on the next edge, state IDLE, and no done pulse.
REQ-022 SHALL treat stop in IDLE as no effect.
REQ-023 SHALL commit a write when wr_en=1 in IDLE, so the new value is readable from the next cycle.
REQ-024 SHALL ignore wr_en while in RUN, leaving the memory unchanged.
REQ-025 SHALL, if start and wr_en arrive in the same IDLE cycle, commit the write and launch the program, with entry 0 reading the post-write value.

Reset
REQ-026 SHALL, while rstb=0 at a clock edge, drive all control outputs, busy and done to 0, return to IDLE, and clear pc and the repeat counter.
REQ-027 SHALL leave control-memory contents unchanged by reset.
REQ-028 SHALL, on reset during RUN, abort the program without a done pulse.

Configuration
REQ-029 SHALL, with macro ROUTER_ADD_SEQ_LOOP_EN defined, add input port loop_en (1 bit).
REQ-030 SHALL, in that configuration, when loop_en=1 at the end of entry last_addr, wrap to pc=0 with no gap cycle, pulse done for 1 cycle and stay in RUN; stop remains the only exit.
REQ-031 SHALL, with the macro undefined, omit the loop_en port and always return to IDLE at program end.

Structure
REQ-032 SHALL place the op-code enum, the entry struct (op, input_sel, output_sel, rpt) and the field-width constants in shared package router_add_seq_pkg.
REQ-033 SHALL implement the control memory as sub-module router_add_seq_cmem: a DEPTH x 12 register file with one write port and a combinational read port.

Verification
REQ-034 SHALL cover a basic program: load {PS out=010 rpt=0, ADD in=01 rpt=2, SUM out=100 rpt=0}, last_addr=2, start -> ps_en for 1 cycle, then add_en with input_sel=01 for 3 cycles, then sum_en with output_sel=100 for 1 cycle, then done pulses 1 cycle later.
REQ-035 SHALL cover abort: stop asserted on the 2nd ADD cycle -> all outputs 0 on the next edge, busy=0, done never asserted.
REQ-036 SHALL cover busy-time inputs: start and wr_en to entry 0 during RUN -> no restart, and a memory readback after done shows entry 0 unchanged.
REQ-037 SHALL cover reserved op code 111 at entry 0 with rpt=3 -> 4 cycles with all enables 0 while busy=1.
REQ-038 SHALL cover loop mode with ROUTER_ADD_SEQ_LOOP_EN defined: loop_en=1, 2-entry program -> done pulses every program period with no gap cycle, and stop ends the loop.
REQ-039 SHALL cover reset: rstb=0 mid-RUN -> all outputs 0 on the next edge, and previously loaded entries replay correctly after a fresh start.
